// File: rtl/branch_predictor_hybrid_pkg.sv
// Shared types for the hybrid (tournament) branch predictor: branch outcome,
// the per-branch metadata carried from decode to commit, and the predictor state.
package branch_predictor_hybrid_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    // The metadata history field is sized for the longest supported GHR.
    // Shorter histories occupy the low bits and are zero-extended.
    localparam int unsigned GHR_MAX_BITS = 16;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic [GHR_MAX_BITS-1:0] ghistory;
        BranchOutcome            prediction;
        BranchOutcome            pred_global;
        BranchOutcome            pred_local;
    } branch_meta_t;

    function automatic int unsigned bp_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_predictor_hybrid_table.sv
// Table of saturating counters: one asynchronous read port for prediction,
// one read-modify-write update port, and an init-write port used by the
// clearing sweep. Storage has no reset so it can map onto RAM.
module bp_sat_counter_table
    import branch_predictor_hybrid_pkg::*;
#(
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic                clk,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_up,
    input  logic                init_en,
    input  logic [IDX_BITS-1:0] init_idx
);

    localparam int unsigned         DEPTH    = 1 << IDX_BITS;
    // Weak value just below the MSB threshold.
    localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0] mem [DEPTH];
    logic [CTR_BITS-1:0] wr_cur;
    logic [CTR_BITS-1:0] wr_next;

    assign rd_ctr = mem[rd_idx];
    assign wr_cur = mem[wr_idx];

    // Saturating step toward the update direction.
    always_comb begin
        wr_next = wr_cur;
        if (wr_up && (wr_cur != '1)) begin
            wr_next = wr_cur + 1'b1;
        end else if (!wr_up && (wr_cur != '0)) begin
            wr_next = wr_cur - 1'b1;
        end
    end

    // Table write: init sweep or feedback update (never both in the same cycle).
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem[init_idx] <= INIT_VAL;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_next;
        end
    end

endmodule

// File: rtl/branch_predictor_hybrid.sv
// Tournament branch predictor: gshare global table, PC-indexed local table and a
// chooser indexed like gshare. Tables are cleared by a sweep after reset; the
// global history is updated speculatively and repaired on a committed mispredict.
module branch_predictor_hybrid
    import branch_predictor_hybrid_pkg::*;
#(
    parameter int unsigned GHR_BITS       = 8,
    parameter int unsigned LOCAL_IDX_BITS = 10,
    parameter int unsigned CTR_BITS       = 2,
    parameter int unsigned STAT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  o_ready,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    output BranchOutcome          o_req_prediction,
    output branch_meta_t          o_req_meta,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  branch_meta_t          i_fb_meta,
    input  BranchOutcome          i_fb_outcome,
    output logic [STAT_WIDTH-1:0] o_fb_count,
    output logic [STAT_WIDTH-1:0] o_mispredict_count
);

    localparam int unsigned SWEEP_BITS = bp_max(GHR_BITS, LOCAL_IDX_BITS);

    bp_state_e               state;
    logic [SWEEP_BITS-1:0]   init_idx;
    logic [GHR_BITS-1:0]     ghr;
    logic                    in_run;

    logic [GHR_BITS-1:0]       req_g_idx;
    logic [LOCAL_IDX_BITS-1:0] req_l_idx;
    logic [GHR_BITS-1:0]       fb_g_idx;
    logic [LOCAL_IDX_BITS-1:0] fb_l_idx;

    logic [CTR_BITS-1:0] g_ctr;
    logic [CTR_BITS-1:0] l_ctr;
    logic [CTR_BITS-1:0] c_ctr;
    BranchOutcome        pred_global;
    BranchOutcome        pred_local;

    logic g_init_en;
    logic l_init_en;
    logic fb_accept;
    logic mispredict;
    logic fb_up;
    logic c_wr_en;
    logic c_up;
    logic unused_bits;

    assign in_run  = (state == BP_RUN);
    assign o_ready = in_run;

    // Word-aligned PC bits; gshare and chooser fold in the global history.
    assign req_g_idx = i_req_pc[GHR_BITS+1:2] ^ ghr;
    assign req_l_idx = i_req_pc[LOCAL_IDX_BITS+1:2];
    assign fb_g_idx  = i_fb_pc[GHR_BITS+1:2] ^ i_fb_meta.ghistory[GHR_BITS-1:0];
    assign fb_l_idx  = i_fb_pc[LOCAL_IDX_BITS+1:2];

    // Sweep covers the deeper table; the shallower one stops once its range is done.
    assign g_init_en = !in_run && ((init_idx >> GHR_BITS) == '0);
    assign l_init_en = !in_run && ((init_idx >> LOCAL_IDX_BITS) == '0);

    assign fb_accept  = i_fb_valid && in_run;
    assign mispredict = fb_accept && (i_fb_outcome != i_fb_meta.prediction);
    assign fb_up      = (i_fb_outcome == TAKEN);
    // Chooser trains only when the components disagreed; up means local was right.
    assign c_wr_en    = fb_accept && (i_fb_meta.pred_global != i_fb_meta.pred_local);
    assign c_up       = (i_fb_outcome == i_fb_meta.pred_local);

    assign pred_global = BranchOutcome'(g_ctr[CTR_BITS-1]);
    assign pred_local  = BranchOutcome'(l_ctr[CTR_BITS-1]);

    assign unused_bits = ^{i_req_pc, i_fb_pc, i_fb_meta.ghistory};

    bp_sat_counter_table #(.IDX_BITS(GHR_BITS), .CTR_BITS(CTR_BITS)) u_gshare (
        .clk      (clk),
        .rd_idx   (req_g_idx),
        .rd_ctr   (g_ctr),
        .wr_en    (fb_accept),
        .wr_idx   (fb_g_idx),
        .wr_up    (fb_up),
        .init_en  (g_init_en),
        .init_idx (init_idx[GHR_BITS-1:0])
    );

    bp_sat_counter_table #(.IDX_BITS(LOCAL_IDX_BITS), .CTR_BITS(CTR_BITS)) u_local (
        .clk      (clk),
        .rd_idx   (req_l_idx),
        .rd_ctr   (l_ctr),
        .wr_en    (fb_accept),
        .wr_idx   (fb_l_idx),
        .wr_up    (fb_up),
        .init_en  (l_init_en),
        .init_idx (init_idx[LOCAL_IDX_BITS-1:0])
    );

    bp_sat_counter_table #(.IDX_BITS(GHR_BITS), .CTR_BITS(CTR_BITS)) u_chooser (
        .clk      (clk),
        .rd_idx   (req_g_idx),
        .rd_ctr   (c_ctr),
        .wr_en    (c_wr_en),
        .wr_idx   (fb_g_idx),
        .wr_up    (c_up),
        .init_en  (g_init_en),
        .init_idx (init_idx[GHR_BITS-1:0])
    );

    // Prediction and metadata; forced to not-taken / zero until the sweep is done.
    always_comb begin
        o_req_prediction = NOT_TAKEN;
        o_req_meta       = '0;
        if (in_run) begin
            o_req_prediction       = c_ctr[CTR_BITS-1] ? pred_local : pred_global;
            o_req_meta.ghistory    = GHR_MAX_BITS'(ghr);
            o_req_meta.prediction  = o_req_prediction;
            o_req_meta.pred_global = pred_global;
            o_req_meta.pred_local  = pred_local;
        end
    end

    // Init sweep sequencing: one entry per cycle, then live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BP_INIT;
            init_idx <= '0;
        end else if (state == BP_INIT) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == '1) begin
                state <= BP_RUN;
            end
        end
    end

    // Speculative history; a mispredict repair wins over a same-cycle request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (in_run) begin
            if (mispredict) begin
                ghr <= {i_fb_meta.ghistory[GHR_BITS-2:0], i_fb_outcome};
            end else if (i_req_valid) begin
                ghr <= {ghr[GHR_BITS-2:0], o_req_prediction};
            end
        end
    end

    // Saturating feedback and mispredict statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_fb_count         <= '0;
            o_mispredict_count <= '0;
        end else begin
            if (fb_accept && (o_fb_count != '1)) begin
                o_fb_count <= o_fb_count + 1'b1;
            end
            if (mispredict && (o_mispredict_count != '1)) begin
                o_mispredict_count <= o_mispredict_count + 1'b1;
            end
        end
    end

endmodule
